// File: rtl/pht_gshare_ctrl.sv
// Gshare PHT sequencer: builds the read index, queues in-flight branches and writes back the PHT; PHT_GSHARE_EN selects gshare, otherwise bimodal.
// Latency: rd_idx/pred_taken same cycle; wb_en/wb_idx/wb_taken/mispredict one cycle after a resolve.
// Backpressure: pred_ready drops while the branch queue is full; resolves are never stalled.

`ifndef GHB_SIZE
`define GHB_SIZE 4
`endif

// In-order queue with a synchronous clear; head entry is visible combinationally.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: wr_rdy low when full; pop only when rd_vld.
module pht_bq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld & wr_rdy & ~clr;
    assign pop    = rd_vld & rd_rdy & ~clr;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset: entries are only read once the count covers them.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module pht_gshare_ctrl #(
    parameter int GHB_SIZE = `GHB_SIZE,
    parameter int PC_LSB   = 2,
    parameter int BQ_DEPTH = 8,
    localparam int CW = $clog2(BQ_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_ready,
    input  logic                pht_taken,
    output logic                pred_taken,
    output logic [GHB_SIZE-1:0] rd_idx,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic                flush,
    output logic [GHB_SIZE-1:0] wb_idx,
    output logic                wb_taken,
    output logic                wb_en,
    output logic                mispredict,
    output logic [CW-1:0]       count
);
`ifdef PHT_GSHARE_EN
    typedef struct packed {
        logic [GHB_SIZE-1:0] ghr_before;
        logic [GHB_SIZE-1:0] idx;
        logic                pred;
    } bq_ent_t;
`else
    typedef struct packed {
        logic [GHB_SIZE-1:0] idx;
        logic                pred;
    } bq_ent_t;
`endif

    bq_ent_t push_ent;
    bq_ent_t head_ent;
    logic    bq_wr_rdy;
    logic    bq_rd_vld;
    logic    accept;
    logic    resolve;
    logic    mis;
    logic    clear;
    logic    unused_pc;

    assign unused_pc  = ^pred_pc;
    assign pred_ready = bq_wr_rdy;
    assign accept     = pred_valid & pred_ready;
    assign pred_taken = pht_taken & accept;
    assign resolve    = res_valid & bq_rd_vld;
    assign mis        = resolve & (res_taken != head_ent.pred);
    // A mispredict squashes younger branches exactly like a flush does.
    assign clear      = flush | mis;

    assign push_ent.idx  = rd_idx;
    assign push_ent.pred = pred_taken;

`ifdef PHT_GSHARE_EN
    logic [GHB_SIZE-1:0] ghr_spec;
    logic [GHB_SIZE-1:0] ghr_arch;
    logic [GHB_SIZE-1:0] ghr_arch_nxt;

    assign rd_idx              = pred_pc[PC_LSB +: GHB_SIZE] ^ ghr_spec;
    assign push_ent.ghr_before = ghr_spec;
    assign ghr_arch_nxt        = resolve ? {ghr_arch[GHB_SIZE-2:0], res_taken} : ghr_arch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_spec <= '0;
            ghr_arch <= '0;
        end else begin
            ghr_arch <= ghr_arch_nxt;
            if (flush)
                ghr_spec <= ghr_arch_nxt;
            else if (mis)
                ghr_spec <= {head_ent.ghr_before[GHB_SIZE-2:0], res_taken};
            else if (accept)
                ghr_spec <= {ghr_spec[GHB_SIZE-2:0], pred_taken};
        end
    end
`else
    assign rd_idx = pred_pc[PC_LSB +: GHB_SIZE];
`endif

    pht_bq_fifo #(
        .WIDTH ($bits(bq_ent_t)),
        .DEPTH (BQ_DEPTH)
    ) u_bq (
        .clock  (clock),
        .reset  (reset),
        .clr    (clear),
        .wr_vld (accept),
        .wr_dat (push_ent),
        .wr_rdy (bq_wr_rdy),
        .rd_vld (bq_rd_vld),
        .rd_rdy (resolve),
        .rd_dat (head_ent),
        .count  (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_en      <= 1'b0;
            wb_idx     <= '0;
            wb_taken   <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            wb_en      <= resolve;
            mispredict <= mis;
            if (resolve) begin
                wb_idx   <= head_ent.idx;
                wb_taken <= res_taken;
            end
        end
    end
endmodule

// File: doc/pht_gshare_ctrl.md
Name: pht_gshare_ctrl

Overview:
- Gshare sequencing controller for the PHT. Forms the PHT read index from fetch PC and speculative global history, and tracks in-flight conditional branches in an in-order branch queue.
- Drives the PHT writeback port when branches resolve.
- Restores global history on mispredict or flush.
- Sits between fetch/branch-resolution logic and the PHT instance.

Parameters:
GHB_SIZE, `GHB_SIZE, PHT index and global history width in bits
PC_LSB, 2, lowest PC bit used for indexing
BQ_DEPTH, 8, in-flight branch queue entries (power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pred_valid  in  1  fetch presents a conditional branch this cycle
pred_pc  in  32  PC of that branch
pred_ready  out  1  queue not full (count < BQ_DEPTH)
pht_taken  in  1  PHT read data for rd_idx (same cycle)
pred_taken  out  1  prediction returned to fetch
rd_idx  out  GHB_SIZE  PHT read index
res_valid  in  1  oldest in-flight branch resolves (in program order)
res_taken  in  1  actual direction
flush  in  1  squash all in-flight branches (exception path)
wb_idx  out  GHB_SIZE  PHT writeback index
wb_taken  out  1  PHT writeback direction
wb_en  out  1  PHT writeback enable
mispredict  out  1  one-cycle pulse: head branch mispredicted
count  out  $clog2(BQ_DEPTH+1)  queue occupancy

Behaviour:
- State:
  - ghr_spec: speculative history.
  - ghr_arch: committed history.
  - Circular queue: head/tail pointers wrap modulo BQ_DEPTH. Each entry holds {idx, pred, ghr_before}.
- rd_idx is combinational: pred_pc[PC_LSB +: GHB_SIZE] ^ ghr_spec.
- pred_taken = pht_taken & pred_valid & pred_ready; otherwise 0.
- Accept:
  - Accept occurs when pred_valid & pred_ready.
  - Enqueue {rd_idx, pred_taken, ghr_spec}.
  - ghr_spec <= {ghr_spec[GHB_SIZE-2:0], pred_taken}.
- Full: pred_ready=0 when count==BQ_DEPTH, even if a dequeue happens the same cycle (no bypass).
- Resolve:
  - Acts on the head when res_valid & count>0. res_valid with an empty queue is ignored: no wb, no pulse.
  - Dequeue the head.
  - ghr_arch <= {ghr_arch[GHB_SIZE-2:0], res_taken}.
  - Next cycle: wb_en=1, wb_idx=head.idx, wb_taken=res_taken. Registered, 1-cycle latency, single-cycle pulse.
- Mispredict (res_taken != head.pred):
  - Next cycle mispredict=1.
  - Queue cleared (count=0).
  - ghr_spec <= {head.ghr_before[GHB_SIZE-2:0], res_taken}.
  - Any prediction accepted the same cycle is discarded: not enqueued, no history update.
- Simultaneous correct resolve + accept: both occur; count unchanged.
- flush:
  - Highest priority.
  - A same-cycle resolve still commits: ghr_arch updated, wb emitted, mispredict pulse if wrong.
  - Queue cleared; ghr_spec <= post-resolve ghr_arch.
  - Same-cycle prediction discarded.
- Reset (asynchronous, any time):
  - ghr_spec=ghr_arch=0, pointers=0, count=0.
  - wb_en=0, wb_idx=0, wb_taken=0, mispredict=0.
  - A pending writeback is dropped.
  - pred_ready=1 once reset deasserts.

Optional Feature:
- PHT_GSHARE_EN defined: gshare indexing as above.
- Undefined (bimodal):
  - rd_idx = pred_pc[PC_LSB +: GHB_SIZE].
  - History registers and ghr_before fields removed.
  - Queue, writeback, mispredict and flush behaviour unchanged.

Test Plan (GHB_SIZE=4, PC_LSB=2, BQ_DEPTH=4, PHT_GSHARE_EN defined):
1. Reset, then pred pc=0x10 with pht_taken=1 -> rd_idx=4'h4, pred_taken=1, count=1. Next pred pc=0x10 -> rd_idx=4'h5.
2. Four accepted preds -> count=4, pred_ready=0; 5th pred_valid ignored. Correct res_valid on the first -> count=3; next cycle wb_en=1, wb_idx equals first idx.
3. Preds taken,taken (ghr_spec=4'b0011); resolve head res_taken=0 -> next cycle wb_en=1, wb_taken=0, mispredict=1, count=0. Then pred pc=0x10 -> rd_idx=4'h4.
4. Three in flight; resolve head correct (taken) and assert flush in the same cycle -> wb_en=1, mispredict=0, count=0, ghr_spec=4'b0001.
5. res_valid=1 with count=0 -> wb_en=0, mispredict=0, state unchanged.
6. Assert reset asynchronously with a wb pending -> wb_en=0 and count=0 immediately; no writeback after release.
